// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control path.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_XOR  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_AND  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_t;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_ILLEGAL = 3'd0,
      CLS_LOAD    = 3'd1,
      CLS_STORE   = 3'd2,
      CLS_BRANCH  = 3'd3,
      CLS_OP      = 3'd4,
      CLS_OPIMM   = 3'd5
   } instr_class_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

   localparam logic [6:0] F7_ZERO = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   // funct3 -> ALU operation for R/I arithmetic; alt selects SUB/SRA
   function automatic alu_op_t funct3_alu_op(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I classifier: instruction class, ALU setup and legality.
module instr_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0]   opcode_i,
   input  logic [2:0]   funct3_i,
   input  logic [6:0]   funct7_i,
   output instr_class_t cls_o,
   output alu_op_t      alu_op_o,
   output logic         alu_src_o,
   output logic         illegal_o
);

   // Class and ALU configuration lookup
   always_comb begin
      cls_o     = CLS_ILLEGAL;
      alu_op_o  = ALU_ADD;
      alu_src_o = 1'b0;
      case (opcode_i)
         OPC_LOAD: begin
            alu_src_o = 1'b1;
            case (funct3_i)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: cls_o = CLS_LOAD;
               default:                                cls_o = CLS_ILLEGAL;
            endcase
         end
         OPC_STORE: begin
            alu_src_o = 1'b1;
            if (funct3_i <= 3'b010) begin
               cls_o = CLS_STORE;
            end else begin
               cls_o = CLS_ILLEGAL;
            end
         end
         OPC_BRANCH: begin
            case (funct3_i[2:1])
               2'b00: begin cls_o = CLS_BRANCH; alu_op_o = ALU_SUB;  end
               2'b10: begin cls_o = CLS_BRANCH; alu_op_o = ALU_SLT;  end
               2'b11: begin cls_o = CLS_BRANCH; alu_op_o = ALU_SLTU; end
               default: cls_o = CLS_ILLEGAL;
            endcase
         end
         OPC_OP: begin
            if (funct7_i == F7_ZERO) begin
               cls_o    = CLS_OP;
               alu_op_o = funct3_alu_op(funct3_i, 1'b0);
            end else if (funct7_i == F7_ALT && (funct3_i == 3'b000 || funct3_i == 3'b101)) begin
               cls_o    = CLS_OP;
               alu_op_o = funct3_alu_op(funct3_i, 1'b1);
            end else begin
               cls_o = CLS_ILLEGAL;
            end
         end
         OPC_OPIMM: begin
            // funct7 only matters for the shift encodings; ADDI never becomes SUB
            alu_src_o = 1'b1;
            case (funct3_i)
               3'b001: begin
                  if (funct7_i == F7_ZERO) begin
                     cls_o    = CLS_OPIMM;
                     alu_op_o = ALU_SLL;
                  end else begin
                     cls_o = CLS_ILLEGAL;
                  end
               end
               3'b101: begin
                  if (funct7_i == F7_ZERO) begin
                     cls_o    = CLS_OPIMM;
                     alu_op_o = ALU_SRL;
                  end else if (funct7_i == F7_ALT) begin
                     cls_o    = CLS_OPIMM;
                     alu_op_o = ALU_SRA;
                  end else begin
                     cls_o = CLS_ILLEGAL;
                  end
               end
               default: begin
                  cls_o    = CLS_OPIMM;
                  alu_op_o = funct3_alu_op(funct3_i, 1'b0);
               end
            endcase
         end
         default: cls_o = CLS_ILLEGAL;
      endcase
   end

   assign illegal_o = (cls_o == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer with memory-handshake timeout,
// illegal-instruction trap and a wrapping retired-instruction counter.
module multicycle_control_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int RETIRE_W    = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic [6:0]          funct7,
   input  logic                alu_zero,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic                imem_req,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_src,
   output logic                dmem_req,
   output logic                mem_read,
   output logic                mem_write,
   output logic                mem_to_reg,
   output logic                alu_src,
   output alu_op_t             alu_op,
   output logic                reg_write,
   output logic                illegal,
   output logic                mem_fault,
   output logic                halted,
   output logic [RETIRE_W-1:0] retired_cnt,
   output state_t              state
);

   localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic            TIMEOUT_EN = (MEM_TIMEOUT != 0);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t              state_q,   state_d;
   logic [WAIT_W-1:0]   wait_q,    wait_d;
   logic                illegal_q, illegal_d;
   logic                fault_q,   fault_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;

   instr_class_t dec_cls;
   alu_op_t      dec_alu_op;
   logic         dec_alu_src;
   logic         dec_illegal;

   logic    imem_req_s, ir_write_s, pc_write_s, pc_src_s, dmem_req_s;
   logic    mem_read_s, mem_write_s, mem_to_reg_s, alu_src_s, reg_write_s;
   alu_op_t alu_op_s;
   logic    retire_s;
   logic    wait_expired_s;
   logic    branch_taken_s;

   instr_decoder u_decoder (
      .opcode_i  (opcode),
      .funct3_i  (funct3),
      .funct7_i  (funct7),
      .cls_o     (dec_cls),
      .alu_op_o  (dec_alu_op),
      .alu_src_o (dec_alu_src),
      .illegal_o (dec_illegal)
   );

   // The limit is hit on the cycle whose wait would make the count reach MEM_TIMEOUT
   assign wait_expired_s = TIMEOUT_EN && (wait_q == WAIT_LAST);
   // BEQ/BGE/BGEU take on zero, BNE/BLT/BLTU on non-zero
   assign branch_taken_s = alu_zero ^ funct3[0] ^ funct3[2];

   // Next-state, sticky flags, retire counter and strobe decode
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      illegal_d    = illegal_q;
      fault_d      = fault_q;
      retire_s     = 1'b0;
      imem_req_s   = 1'b0;
      ir_write_s   = 1'b0;
      pc_write_s   = 1'b0;
      pc_src_s     = 1'b0;
      dmem_req_s   = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      mem_to_reg_s = 1'b0;
      alu_src_s    = 1'b0;
      reg_write_s  = 1'b0;
      alu_op_s     = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            imem_req_s = 1'b1;
            if (imem_ready) begin
               ir_write_s = 1'b1;
               state_d    = S_DECODE;
               wait_d     = '0;
            end else if (wait_expired_s) begin
               state_d = S_TRAP;
               fault_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_DECODE: begin
            if (dec_illegal) begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            alu_op_s  = dec_alu_op;
            alu_src_s = dec_alu_src;
            case (dec_cls)
               CLS_BRANCH: begin
                  pc_write_s = 1'b1;
                  pc_src_s   = branch_taken_s;
                  retire_s   = 1'b1;
                  state_d    = S_FETCH;
                  wait_d     = '0;
               end
               CLS_LOAD, CLS_STORE: begin
                  state_d = S_MEM;
                  wait_d  = '0;
               end
               CLS_OP, CLS_OPIMM: state_d = S_WRITEBACK;
               default: begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            alu_op_s    = dec_alu_op;
            alu_src_s   = dec_alu_src;
            dmem_req_s  = 1'b1;
            mem_read_s  = (dec_cls == CLS_LOAD);
            mem_write_s = (dec_cls == CLS_STORE);
            if (dmem_ready) begin
               if (dec_cls == CLS_STORE) begin
                  pc_write_s = 1'b1;
                  retire_s   = 1'b1;
                  state_d    = S_FETCH;
                  wait_d     = '0;
               end else begin
                  state_d = S_WRITEBACK;
               end
            end else if (wait_expired_s) begin
               state_d = S_TRAP;
               fault_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_WRITEBACK: begin
            alu_op_s     = dec_alu_op;
            alu_src_s    = dec_alu_src;
            reg_write_s  = 1'b1;
            mem_to_reg_s = (dec_cls == CLS_LOAD);
            pc_write_s   = 1'b1;
            retire_s     = 1'b1;
            state_d      = S_FETCH;
            wait_d       = '0;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
      retired_d = retire_s ? (retired_q + RETIRE_W'(1)) : retired_q;
   end

   // State and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         fault_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
      end
   end

   // Strobes are Mealy; gating with rst_n drops them the moment reset asserts
   assign imem_req    = imem_req_s   & rst_n;
   assign ir_write    = ir_write_s   & rst_n;
   assign pc_write    = pc_write_s   & rst_n;
   assign pc_src      = pc_src_s     & rst_n;
   assign dmem_req    = dmem_req_s   & rst_n;
   assign mem_read    = mem_read_s   & rst_n;
   assign mem_write   = mem_write_s  & rst_n;
   assign mem_to_reg  = mem_to_reg_s & rst_n;
   assign alu_src     = alu_src_s    & rst_n;
   assign reg_write   = reg_write_s  & rst_n;
   assign alu_op      = alu_op_s;
   assign illegal     = illegal_q;
   assign mem_fault   = fault_q;
   assign halted      = (state_q == S_TRAP);
   assign retired_cnt = retired_q;
   assign state       = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RV32I datapath. It replaces single-cycle control with a FETCH/DECODE/EXECUTE/MEM/WRITEBACK state machine. It drives the instruction-memory and data-memory ready handshakes, the PC and IR write enables, ALU configuration and register-file write. It also keeps a retired-instruction counter and halts on illegal instructions and memory timeouts.

Parameters:
RETIRE_W, 32, width of retired-instruction counter; wraps modulo 2^RETIRE_W
MEM_TIMEOUT, 15, max wait cycles for imem_ready/dmem_ready before fault; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
alu_zero  in  1  ALU zero flag (result == 0)
imem_ready  in  1  instruction memory returns word this cycle
dmem_ready  in  1  data memory completes access this cycle
imem_req  out  1  instruction fetch request
ir_write  out  1  load IR from instruction memory
pc_write  out  1  update PC
pc_src  out  1  0: PC+4, 1: branch target
dmem_req  out  1  data memory request
mem_read  out  1  load access
mem_write  out  1  store access
mem_to_reg  out  1  writeback source: 1 memory, 0 ALU
alu_src  out  1  ALU operand B: 1 immediate, 0 rs2
alu_op  out  4  ALU operation code (package enum)
reg_write  out  1  register file write enable
illegal  out  1  sticky: illegal instruction trapped
mem_fault  out  1  sticky: memory handshake timeout
halted  out  1  FSM in TRAP
retired_cnt  out  RETIRE_W  instructions retired
state  out  3  current state, debug

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n; all state and outputs clear immediately when rst_n is low.
- Reset values: state=FETCH, all strobes 0, alu_op=ADD, illegal=0, mem_fault=0, retired_cnt=0, wait counter=0.
- Strobes are decoded from state and the current instruction. ir_write and pc_write are Mealy: they are asserted only in the cycle the handshake completes or the instruction retires.
- The IR is written only in FETCH, so opcode/funct fields stay stable from DECODE until retire.
- FETCH: imem_req=1. On imem_ready: ir_write=1, next state DECODE.
- DECODE: classify the instruction. Illegal -> TRAP with illegal set. Otherwise -> EXECUTE.
- Legal classes:
  - LOAD 0000011 with funct3 in {000,001,010,100,101}
  - STORE 0100011 with funct3 in {000,001,010}
  - BRANCH 1100011 with funct3 not in {010,011}
  - OP 0110011
  - OP-IMM 0010011
- OP: funct7 must be 0x00. funct7=0x20 is legal only for funct3 000 (SUB) and 101 (SRA).
- OP-IMM: funct3 001 requires funct7=0x00. funct3 101 accepts 0x00 (SRL) or 0x20 (SRA). Other funct3 values ignore funct7.
- alu_op mapping:
  - ADD for LOAD/STORE
  - R/I use funct3 map: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND
  - BRANCH: funct3 00x -> SUB; 10x -> SLT; 11x -> SLTU
- alu_src=1 for LOAD, STORE and OP-IMM; 0 otherwise.
- EXECUTE:
  - BRANCH: pc_write=1, retire, -> FETCH. pc_src=1 when taken. Taken conditions: BEQ zero, BNE !zero, BLT/BLTU !zero, BGE/BGEU zero.
  - OP/OP-IMM -> WRITEBACK.
  - LOAD/STORE -> MEM.
- MEM: dmem_req=1; mem_read=1 for LOAD, mem_write=1 for STORE. On dmem_ready:
  - STORE: pc_write=1, pc_src=0, retire, -> FETCH.
  - LOAD: -> WRITEBACK.
- WRITEBACK: reg_write=1, mem_to_reg=1 for LOAD, pc_write=1, pc_src=0, retire, -> FETCH.
- alu_op and alu_src are held from EXECUTE through WRITEBACK.
- Retire: retired_cnt increments by 1 in the retire cycle and wraps to 0 from all-ones.
- Timeout:
  - Wait counter clears on entry to FETCH or MEM and increments each cycle while ready is low.
  - When the counter reaches MEM_TIMEOUT with ready still low -> TRAP with mem_fault set.
  - If ready arrives in the same cycle the limit is reached, ready wins.
  - MEM_TIMEOUT=0 disables the timeout: wait forever.
- TRAP: halted=1, all strobes 0, absorbing until rst_n is asserted.
- Reset mid-instruction: strobes drop asynchronously and there is no partial retire. After reset is released, execution restarts at FETCH.

Decomposition:
- Package riscv_ctrl_pkg:
  - alu_op_t: ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9
  - opcode constants
  - state_t: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5
  - instr_class_t
- Sub-module instr_decoder: combinational; opcode/funct3/funct7 -> class, alu_op, alu_src, illegal. The FSM top instantiates it.

Test Plan:
- add x3,x1,x2 (0x002081B3), imem_ready after 1 wait cycle -> states FETCH,FETCH,DECODE,EXECUTE,WRITEBACK. alu_op=0, reg_write=1 exactly once, retired_cnt=1.
- lw (opcode 0000011, funct3 010), dmem_ready after 3 cycles -> mem_read held 4 cycles, then WRITEBACK with mem_to_reg=1, alu_src=1.
- beq with alu_zero=1, then bne with alu_zero=1 -> pc_src=1 then pc_src=0. Both assert pc_write in EXECUTE with reg_write=0.
- R-type funct3=100, funct7=0x20 -> illegal=1, halted=1, state=TRAP; no pc_write or reg_write after it.
- MEM_TIMEOUT=4, store with dmem_ready never high -> mem_fault=1 after 4 MEM cycles. Repeat with ready exactly at cycle 4 -> store retires, no fault.
- rst_n low during MEM, then release -> state=FETCH, strobes 0, retired_cnt=0. Separately: RETIRE_W=4 with 16 retires -> counter wraps to 0.
